restoring_div_n: RTL and testbench

Sequential signed integer divider, the inverse companion of the right-shift multiplier. It computes Quotient and Remainder of two N-bit two's-complement operands using one restoring shift-subtract iteration per clock. Result semantics match Verilog signed / and %: truncation toward zero, and the remainder takes the dividend's sign. It sits beside the multiplier in the arithmetic datapath and reports completion with a done_flag.

---
 rtl/restoring_div_n_pkg.sv | 13 +
 rtl/restoring_div_n_div_step.sv | 29 ++
 rtl/restoring_div_n.sv | 124 ++++++++++++
 tb/tb_restoring_div_n.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/restoring_div_n_pkg.sv
// Shared definitions for the sequential arithmetic datapath (divider and multiplier).
package restoring_div_n_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/restoring_div_n_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes; purely combinational.
module restoring_div_n_div_step
    import restoring_div_n_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic [N:0]   a,
    input  logic [N-1:0] q,
    input  logic [N:0]   dvsr,
    output logic [N:0]   a_next,
    output logic [N-1:0] q_next
);

    localparam int AW = N + 1;
    localparam int SW = N + 2;

    logic [SW-1:0] shifted;
    logic [SW-1:0] dvsr_ext;
    logic          fits;

    // The partial remainder stays below the divisor, so after the shift it is below
    // twice the divisor and the result always fits back into N+1 bits.
    assign shifted  = {a, q[N-1]};
    assign dvsr_ext = {1'b0, dvsr};
    assign fits     = (shifted >= dvsr_ext);
    assign a_next   = fits ? AW'(shifted - dvsr_ext) : AW'(shifted);
    assign q_next   = {q[N-2:0], fits};

endmodule

// File: rtl/restoring_div_n.sv
// Sequential signed divider: one restoring iteration per clock, truncating toward zero.
module restoring_div_n
    import restoring_div_n_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         busy,
    output logic         done_flag,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_t state, state_next;

    logic [CW-1:0] count;
    logic [N:0]    a_reg;
    logic [N-1:0]  q_reg;
    logic [N:0]    dvsr_mag;
    logic [N-1:0]  dividend_reg;
    logic          sign_q;
    logic          sign_r;
    logic          dbz;

    logic [N:0]    dividend_ext, divisor_ext;
    logic [N:0]    dividend_mag, divisor_mag;
    logic          divisor_zero;
    logic [N:0]    step_a;
    logic [N-1:0]  step_q;

    // Magnitudes are N+1 bits wide so the most negative operand has a representable absolute value.
    assign dividend_ext = {Dividend[N-1], Dividend};
    assign divisor_ext  = {Divisor[N-1], Divisor};
    assign dividend_mag = Dividend[N-1] ? -dividend_ext : dividend_ext;
    assign divisor_mag  = Divisor[N-1] ? -divisor_ext : divisor_ext;
    assign divisor_zero = (Divisor == '0);

    restoring_div_n_div_step #(.N(N)) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .dvsr   (dvsr_mag),
        .a_next (step_a),
        .q_next (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = divisor_zero ? FIX : RUN;
            RUN:        if (count == LAST) state_next = FIX;
            FIX:        state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            a_reg        <= '0;
            q_reg        <= '0;
            dvsr_mag     <= '0;
            dividend_reg <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            dbz          <= 1'b0;
            Quotient     <= '0;
            Remainder    <= '0;
            busy         <= 1'b0;
            done_flag    <= 1'b0;
            div_by_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sign_q       <= Dividend[N-1] ^ Divisor[N-1];
                        sign_r       <= Dividend[N-1];
                        q_reg        <= N'(dividend_mag);
                        a_reg        <= '0;
                        dvsr_mag     <= divisor_mag;
                        dividend_reg <= Dividend;
                        dbz          <= divisor_zero;
                        count        <= '0;
                        busy         <= 1'b1;
                        done_flag    <= 1'b0;
                        div_by_zero  <= 1'b0;
                    end
                end
                RUN: begin
                    a_reg <= step_a;
                    q_reg <= step_q;
                    count <= count + CW'(1);
                end
                FIX: begin
                    // Negating a zero remainder yields zero, so no special case is needed.
                    if (dbz) begin
                        Quotient    <= '1;
                        Remainder   <= dividend_reg;
                        div_by_zero <= 1'b1;
                    end else begin
                        Quotient  <= sign_q ? -q_reg : q_reg;
                        Remainder <= sign_r ? N'(-a_reg) : N'(a_reg);
                    end
                    done_flag <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div_n.sv
// Randomized scoreboard bench for restoring_div_n against an arithmetic reference model.
module tb_restoring_div_n;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           accept;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] Dividend;
    logic [N-1:0] Divisor;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         busy;
    logic         done_flag;
    logic         div_by_zero;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    logic done_q   = 1'b0;
    exp_t exp_q[$];

    restoring_div_n #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .busy        (busy),
        .done_flag   (done_flag),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cycle);
        end
    endtask

    // Reference: signed division in 64-bit arithmetic, truncating toward zero, then wrapped to N bits.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int acc);
        exp_t   e;
        longint sa, sb, qq, rr;
        e.accept = acc;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            qq    = sa / sb;
            rr    = sa - qq * sb;
            e.q   = N'(qq);
            e.r   = N'(rr);
            e.dbz = 1'b0;
            e.lat = N + 1;
        end
        return e;
    endfunction

    // Monitor: every rising done_flag retires the oldest outstanding operation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done_flag && !done_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL spurious_done actual=1 required=0 at cycle %0d", cycle);
            end else begin
                e = exp_q.pop_front();
                check_output("quotient", Quotient, e.q);
                check_output("remainder", Remainder, e.r);
                check_output("div_by_zero", div_by_zero, e.dbz);
                check_output("latency", cycle - e.accept, e.lat);
            end
        end
        done_q = done_flag;
    end

    task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b, cycle + 1));
        @(negedge clk);
        start    = 1'b0;
        Dividend = $urandom;
        Divisor  = $urandom;
        check_output("done_cleared", done_flag, 0);
        check_output("busy_set", busy, 1);
        check_output("dbz_cleared", div_by_zero, 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < N + 8 && !done_flag; i++) @(negedge clk);
        if (!done_flag) check_output("done_timeout", done_flag, 1);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_quotient", Quotient, 0);
        check_output("rst_remainder", Remainder, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done_flag, 0);
        check_output("rst_dbz", div_by_zero, 0);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        rst      = 1'b1;
        start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Basic operation with cycle-by-cycle busy/done timing.
        apply_stimulus(35, 7);
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            check_output("run_busy", busy, 1);
            check_output("run_done", done_flag, 0);
        end
        @(negedge clk);
        check_output("fin_busy", busy, 0);
        check_output("fin_done", done_flag, 1);

        apply_stimulus(-7, 2);            wait_done();
        apply_stimulus(7, -2);            wait_done();
        apply_stimulus(-21, -5);          wait_done();
        apply_stimulus(32'h80000000, -1); wait_done();
        apply_stimulus(32'h7ff7a099, 32'hf0f7a099); wait_done();

        // Divide by zero finishes one edge after acceptance.
        apply_stimulus(100, 0);
        @(negedge clk);
        check_output("dbz_done", done_flag, 1);
        check_output("dbz_flag", div_by_zero, 1);
        check_output("dbz_busy", busy, 0);
        apply_stimulus(50, 3);            wait_done();

        // Reset in the middle of an iteration sequence discards the operation.
        apply_stimulus(123456789, 77);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        void'(exp_q.pop_back());
        apply_stimulus(-999, 10);         wait_done();

        // A start pulse during RUN must not disturb result or timing.
        apply_stimulus(-1000, 9);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        Dividend = 7;
        Divisor  = 1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Back-to-back launch straight from DONE.
        apply_stimulus(300, -4);          wait_done();

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = N'($signed($urandom_range(0, 40)) - 20);
                2:       rb = '1;
                default: rb = $urandom;
            endcase
            apply_stimulus(ra, rb);
            wait_done();
        end

        repeat (3) @(negedge clk);
        check_output("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
